// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches two operands and a carry-in, pushes them
// LSB first through a single 1-bit full_adder cell, and assembles the result word.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             CARRY_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM_OUT,
    output logic             CARRY_OUT
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] sum_out_r;
    logic             carry_out_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] result_nxt_s;
    logic             accept_s;

    full_adder u_fa (
        .a         (a_sh_r[0]),
        .b         (b_sh_r[0]),
        .carry_in  (carry_r),
        .sum       (fa_sum_s),
        .carry_out (fa_cout_s)
    );

    // Each new sum bit enters at the MSB so the word is in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_result_w1
            assign result_nxt_s = fa_sum_s;
        end else begin : g_result_wn
            assign result_nxt_s = {fa_sum_s, result_r[WIDTH-1:1]};
        end
    endgenerate

    // A new request is taken only when not mid-operation (IDLE or the FIN cycle).
    always_comb begin
        accept_s = 1'b0;
        if (START && ((state_r == ST_IDLE) || (state_r == ST_FIN))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer: operand load, per-bit shift/carry update, and result publication.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            sum_out_r   <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    if (accept_s) begin
                        a_sh_r   <= A_IN;
                        b_sh_r   <= B_IN;
                        carry_r  <= CARRY_IN;
                        cnt_r    <= {CNT_W{1'b0}};
                        result_r <= {WIDTH{1'b0}};
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    carry_r  <= fa_cout_s;
                    result_r <= result_nxt_s;
                    if (cnt_r == LAST_BIT) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        sum_out_r   <= result_nxt_s;
                        carry_out_r <= fa_cout_s;
                        state_r     <= ST_FIN;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        cnt_r       <= cnt_r + CNT_W'(1);
                        state_r     <= ST_RUN;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign SUM_OUT   = sum_out_r;
    assign CARRY_OUT = carry_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing, back-to-back,
// ignored-START and reset-abort scenarios, plus a 1-bit instance checked exhaustively.

module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum_out;
    logic       c_out;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       c1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       c_out1;

    int n_assert = 0;
    int n_fail   = 0;

    // Last published result, used to check the outputs hold between completions.
    logic [7:0] held_sum;
    logic       held_cout;

    serial_adder #(.WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .A_IN(a_in), .B_IN(b_in),
        .CARRY_IN(c_in), .BUSY(busy), .DONE(done), .SUM_OUT(sum_out),
        .CARRY_OUT(c_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .A_IN(a1), .B_IN(b1),
        .CARRY_IN(c1), .BUSY(busy1), .DONE(done1), .SUM_OUT(sum1),
        .CARRY_OUT(c_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected packed as {BUSY, DONE, CARRY_OUT, SUM_OUT}.
    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed {busy,done,cout,sum}=%h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then follow it through RUN into FIN.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] e_sum, input logic e_cout);
        a_in = a; b_in = b; c_in = c; start = 1'b1;
        tick();
        start = 1'b0; a_in = 8'h00; b_in = 8'h00; c_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check({tag, "_run"}, {busy, done, c_out, sum_out}, {1'b1, 1'b0, held_cout, held_sum});
            tick();
        end
        check({tag, "_fin"}, {busy, done, c_out, sum_out}, {1'b0, 1'b1, e_cout, e_sum});
        held_sum = e_sum; held_cout = e_cout;
        tick();
        check({tag, "_idle"}, {busy, done, c_out, sum_out}, {1'b0, 1'b0, held_cout, held_sum});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; c_in = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        held_sum = 8'h00; held_cout = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_idle", {busy, done, c_out, sum_out}, {1'b0, 1'b0, 1'b0, 8'h00});
        end

        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // START during RUN is ignored; START held through FIN chains the next op
        a_in = 8'h10; b_in = 8'h20; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                start = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in = 1'b0;
            end
            check("ignore_run", {busy, done, c_out, sum_out}, {1'b1, 1'b0, held_cout, held_sum});
            tick();
        end
        check("ignore_fin", {busy, done, c_out, sum_out}, {1'b0, 1'b1, 1'b0, 8'h30});
        held_sum = 8'h30; held_cout = 1'b0;
        tick();
        start = 1'b0; a_in = 8'h00; b_in = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            check("b2b_run", {busy, done, c_out, sum_out}, {1'b1, 1'b0, held_cout, held_sum});
            tick();
        end
        check("b2b_fin", {busy, done, c_out, sum_out}, {1'b0, 1'b1, 1'b0, 8'hFF});
        held_sum = 8'hFF; held_cout = 1'b0;
        tick();
        check("b2b_idle", {busy, done, c_out, sum_out}, {1'b0, 1'b0, 1'b0, 8'hFF});

        // Reset mid-RUN aborts asynchronously with no DONE
        a_in = 8'h80; b_in = 8'h80; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort_pre", {busy, done, c_out, sum_out}, {1'b1, 1'b0, 1'b0, 8'hFF});
        #2 rst = 1'b1;
        #1;
        check("abort_async", {busy, done, c_out, sum_out}, {1'b0, 1'b0, 1'b0, 8'h00});
        tick();
        rst = 1'b0;
        held_sum = 8'h00; held_cout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_quiet", {busy, done, c_out, sum_out}, {1'b0, 1'b0, 1'b0, 8'h00});
        end
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Reset during FIN drops DONE at once
        a_in = 8'h01; b_in = 8'h02; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        check("fin_pre_rst", {busy, done, c_out, sum_out}, {1'b0, 1'b1, 1'b0, 8'h03});
        #2 rst = 1'b1;
        #1;
        check("fin_rst", {busy, done, c_out, sum_out}, {1'b0, 1'b0, 1'b0, 8'h00});
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=1: every operand/carry combination, one RUN cycle then FIN
        for (int v = 0; v < 8; v++) begin
            logic [1:0] ref_v;
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); c1 = 1'(v);
            ref_v = 2'(a1) + 2'(b1) + 2'(c1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_run", {7'd0, busy1, done1, c_out1, sum1}, {7'd0, 1'b1, 1'b0, 2'b00} | (v == 0 ? 11'd0 : {7'd0, 2'b00, held1_prev(v)}));
            tick();
            check("w1_fin", {7'd0, busy1, done1, c_out1, sum1}, {7'd0, 1'b0, 1'b1, ref_v});
            tick();
            check("w1_idle", {7'd0, busy1, done1, c_out1, sum1}, {7'd0, 1'b0, 1'b0, ref_v});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Result of the previous 1-bit vector, as {cout, sum}, for the hold check during RUN.
    function automatic logic [1:0] held1_prev(input int v);
        int p;
        p = v - 1;
        return 2'(((p >> 2) & 1) + ((p >> 1) & 1) + (p & 1));
    endfunction

endmodule
